rc_stim_pulse_gen: RTL and testbench

// - Stimulus source for the msdsl RC models: drives the fixed-point v_in port with a

---
 rtl/rc_stim_pkg.sv | 14 +
 rtl/rc_stim_slew.sv | 26 ++
 rtl/rc_stim_pulse_gen.sv | 113 +++++++++++
 tb/tb_rc_stim_pulse_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rc_stim_pkg.sv
// rc_stim_pkg: shared state encoding, default fixed-point format and a real-to-code helper.
package rc_stim_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_EXP   = -12;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    function automatic longint to_fixed(input real x, input int exp);
        return longint'(x * (2.0 ** real'(-exp)));
    endfunction

endpackage

// File: rtl/rc_stim_slew.sv
// rc_stim_slew: registered slew limiter moving v_out toward target by at most slew per cycle.
module rc_stim_slew #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] slew,
    output logic [WIDTH-1:0] v_out
);

    logic signed [WIDTH:0] diff, lim, step;

    // One extra bit keeps the full-swing difference exact; the clamped step never overshoots target.
    always_comb begin
        diff = {target[WIDTH-1], target} - {v_out[WIDTH-1], v_out};
        lim  = {1'b0, slew};
        step = slew == '0 ? diff : diff > lim ? lim : diff < -lim ? -lim : diff;
    end

    always_ff @(posedge clk) begin
        if (rst) v_out <= '0;
        else     v_out <= v_out + step[WIDTH-1:0];
    end

endmodule

// File: rtl/rc_stim_pulse_gen.sv
// rc_stim_pulse_gen: start/busy/done pulse-train sequencer feeding a slew-limited fixed-point v_out.
module rc_stim_pulse_gen
    import rc_stim_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXP   = DEF_EXP,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lvl_hi,
    input  logic [WIDTH-1:0] lvl_lo,
    input  logic [CNT_W-1:0] t_high,
    input  logic [CNT_W-1:0] t_low,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic [WIDTH-1:0] slew,
    output logic [WIDTH-1:0] v_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);

    if (EXP >= WIDTH) begin : g_exp_chk
        $error("EXP leaves no representable range for WIDTH");
    end

    state_t state, state_n;
    logic [WIDTH-1:0] hi_q, lo_q, slew_q, target, target_n;
    logic [CNT_W-1:0] th_q, tl_q, n_q, cnt, cnt_n, idx_n;
    logic accept;

    // Phase counter counts down to zero, so a zero duration still lasts one cycle.
    function automatic logic [CNT_W-1:0] last(input logic [CNT_W-1:0] t);
        return t == '0 ? '0 : t - CNT_W'(1);
    endfunction

    assign accept = state == IDLE && start && !abort;

    always_comb begin
        state_n  = state;
        target_n = target;
        cnt_n    = cnt - CNT_W'(1);
        idx_n    = pulse_idx;
        case (state)
            IDLE: if (accept) begin
                state_n  = n_pulses == '0 ? DONE : HIGH;
                target_n = n_pulses == '0 ? lvl_lo : lvl_hi;
                cnt_n    = last(t_high);
                idx_n    = '0;
            end
            HIGH: if (cnt == '0) begin
                state_n  = LOW;
                target_n = lo_q;
                cnt_n    = last(tl_q);
            end
            LOW: if (cnt == '0) begin
                idx_n    = pulse_idx + CNT_W'(1);
                state_n  = idx_n == n_q ? DONE : HIGH;
                target_n = idx_n == n_q ? lo_q : hi_q;
                cnt_n    = last(th_q);
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n  = IDLE;
            target_n = lo_q;
            idx_n    = pulse_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            target    <= '0;
            cnt       <= '0;
            pulse_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            slew_q    <= '0;
            th_q      <= '0;
            tl_q      <= '0;
            n_q       <= '0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            cnt       <= cnt_n;
            pulse_idx <= idx_n;
            busy      <= state_n == HIGH || state_n == LOW;
            done      <= state_n == DONE;
            if (accept) begin
                hi_q   <= lvl_hi;
                lo_q   <= lvl_lo;
                slew_q <= slew;
                th_q   <= t_high;
                tl_q   <= t_low;
                n_q    <= n_pulses;
            end
        end
    end

    rc_stim_slew #(.WIDTH(WIDTH)) u_slew (
        .clk    (clk),
        .rst    (rst),
        .target (target),
        .slew   (slew_q),
        .v_out  (v_out)
    );

endmodule

// File: tb/tb_rc_stim_pulse_gen.sv
// tb_rc_stim_pulse_gen: sequence-level reference model plus directed literal checks.
module tb_rc_stim_pulse_gen;
    import rc_stim_pkg::*;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [15:0] lvl_hi = '0, lvl_lo = '0, t_high = '0, t_low = '0, n_pulses = '0, slew = '0;
    logic [15:0] v_out, pulse_idx;
    logic busy, done;

    logic w_start = 1'b0, w_abort = 1'b0;
    logic [15:0] w_hi = 16'd100, w_lo = 16'd0, w_slew = '0, w_v;
    logic [3:0] w_th = '0, w_tl = '0, w_n = 4'd15, w_idx;
    logic w_busy, w_done;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    rc_stim_pulse_gen dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lvl_hi(lvl_hi), .lvl_lo(lvl_lo), .t_high(t_high), .t_low(t_low),
        .n_pulses(n_pulses), .slew(slew), .v_out(v_out), .busy(busy),
        .done(done), .pulse_idx(pulse_idx)
    );

    rc_stim_pulse_gen #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .abort(w_abort),
        .lvl_hi(w_hi), .lvl_lo(w_lo), .t_high(w_th), .t_low(w_tl),
        .n_pulses(w_n), .slew(w_slew), .v_out(w_v), .busy(w_busy),
        .done(w_done), .pulse_idx(w_idx)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a started sequence is expanded into a per-cycle schedule of
    // (target, busy, done, completed pulses); v_out then chases the previous target.
    typedef struct {int tgt; bit busy; bit done; int idx;} ent_t;
    ent_t q[$];
    ent_t e;
    int m_v = 0, m_tgt = 0, m_idx = 0, m_lo = 0, m_slew = 0, th, tl, np;
    bit m_busy = 0, m_done = 0, act = 0, chk_en = 0;

    function automatic int slew_to(input int v, input int t, input int s);
        int d;
        d = t - v;
        if (s == 0) return t;
        if (d > s) d = s;
        else if (d < -s) d = -s;
        return v + d;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_v = 0; m_tgt = 0; m_idx = 0; m_lo = 0; m_slew = 0;
            m_busy = 0; m_done = 0; act = 0; chk_en = 1;
        end else begin
            m_v = slew_to(m_v, m_tgt, m_slew);
            if (act && abort) begin
                q.delete();
                act = 0; m_tgt = m_lo; m_busy = 0; m_done = 0;
            end else begin
                if (!act && start && !abort) begin
                    m_lo = int'($signed(lvl_lo));
                    m_slew = int'(slew);
                    th = t_high == 0 ? 1 : int'(t_high);
                    tl = t_low == 0 ? 1 : int'(t_low);
                    np = int'(n_pulses);
                    for (int p = 0; p < np; p++) begin
                        for (int i = 0; i < th; i++) q.push_back(ent_t'{int'($signed(lvl_hi)), 1'b1, 1'b0, p});
                        for (int i = 0; i < tl; i++) q.push_back(ent_t'{m_lo, 1'b1, 1'b0, p});
                    end
                    q.push_back(ent_t'{m_lo, 1'b0, 1'b1, np});
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    act = 1; m_tgt = e.tgt; m_busy = e.busy; m_done = e.done; m_idx = e.idx;
                end else begin
                    act = 0; m_busy = 0; m_done = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model v_out", $signed(v_out), m_v);
            chk("model busy", int'(busy), int'(m_busy));
            chk("model done", int'(done), int'(m_done));
            chk("model pulse_idx", int'(pulse_idx), m_idx);
        end
    end

    // Leaves the bench one negedge into the first cycle after start was sampled.
    task automatic launch(input int hi, input int lo, input int th_i, input int tl_i,
                          input int n, input int s);
        @(negedge clk);
        lvl_hi = 16'(hi); lvl_lo = 16'(lo); t_high = 16'(th_i); t_low = 16'(tl_i);
        n_pulses = 16'(n); slew = 16'(s); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(done), 1);
    endtask

    int e1[12] = '{0, 0, 4096, 4096, 4096, 0, 0, 4096, 4096, 4096, 0, 0};
    int e2[7]  = '{0, 0, 1024, 2048, 3072, 4096, 4096};
    int e6[8]  = '{0, 0, 32767, 32767, 32767, 0, -32767, -32768};

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("reset v_out", $signed(v_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset pulse_idx", int'(pulse_idx), 0);
        rst = 1'b0;

        launch(int'(to_fixed(1.0, DEF_EXP)), 0, 3, 2, 2, 0);
        for (int i = 1; i <= 11; i++) begin
            if (i > 1) @(negedge clk);
            chk($sformatf("t1 v_out k%0d", i), $signed(v_out), e1[i]);
            if (i == 1) chk("t1 busy k1", int'(busy), 1);
            if (i == 10) chk("t1 done k10", int'(done), 0);
        end
        chk("t1 done k11", int'(done), 1);
        chk("t1 pulse_idx end", int'(pulse_idx), 2);
        @(negedge clk);
        chk("t1 done single", int'(done), 0);

        launch(4096, 0, 8, 1, 1, 1024);
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) @(negedge clk);
            chk($sformatf("t2 v_out k%0d", i), $signed(v_out), e2[i]);
        end
        wait_done("t2 done", 20);
        repeat (6) @(negedge clk);

        launch(4096, -2048, 3, 3, 0, 512);
        chk("t3 done k1", int'(done), 1);
        chk("t3 busy k1", int'(busy), 0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3 v_out k%0d", i), $signed(v_out), -512 * (i - 1));
        end
        repeat (2) @(negedge clk);

        launch(4096, -1000, 10, 2, 3, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4 abort busy", int'(busy), 0);
        chk("t4 abort pulse_idx", int'(pulse_idx), 0);
        @(negedge clk);
        chk("t4 v_out lo", $signed(v_out), -1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4 no done", int'(done), 0);
        end

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("t5 start+abort busy", int'(busy), 0);
        @(negedge clk);
        chk("t5 start+abort done", int'(done), 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(32767, -32768, 3, 3, 1, 16'h7FFF);
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) @(negedge clk);
            chk($sformatf("t6 v_out k%0d", i), $signed(v_out), e6[i]);
        end
        chk("t6 done k7", int'(done), 1);
        repeat (2) @(negedge clk);

        launch(4096, 1000, 2, 3, 3, 0);
        repeat (8) @(negedge clk);
        chk("t7 pulse_idx mid", int'(pulse_idx), 1);
        chk("t7 busy mid", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t7 rst v_out", $signed(v_out), 0);
        chk("t7 rst busy", int'(busy), 0);
        chk("t7 rst pulse_idx", int'(pulse_idx), 0);
        launch(2048, 0, 1, 1, 1, 0);
        chk("t7 restart busy", int'(busy), 1);
        wait_done("t7 restart done", 10);
        repeat (2) @(negedge clk);

        @(negedge clk);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        chk("t8 wrap busy", int'(w_busy), 1);
        k = 1;
        while (!w_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t8 wrap done cycle", k, 31);
        chk("t8 wrap pulse_idx", int'(w_idx), 15);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
